mmio_kbd_dsp: RTL and testbench
===============================

MMIO_KBD_DSP -- requirements
Module: mmio_kbd_dsp

Interface
REQ-001 Parameters SHALL be: WIDTH, 16, bus/register width; CHAR_W, 8, character width (CHAR_W <= WIDTH-3); KBD_DEPTH, 4, keyboard FIFO entries (power of 2, >= 2); BASE_ADDR, 16'hFE00, address of KBSR (KBDR = +2, DSR = +4, DDR = +6).
REQ-002 i_Clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_Rst_n  input  1  synchronous, active-low reset, sampled on rising edge of i_Clk.
REQ-004 MAR_OUT  input  WIDTH  access address.
REQ-005 MEM_EN  input  1  access strobe; one access per cycle when high.
REQ-006 R_W  input  1  1 = write, 0 = read.
REQ-007 MDR_OUT  input  WIDTH  write data.
REQ-008 IO_SEL  output  1  combinational; high when MAR_OUT matches one of the four register addresses.
REQ-009 IO_RDATA  output  WIDTH  combinational read data for the selected register; 0 when IO_SEL low.
REQ-010 KBD_VALID  input  1  keyboard character offered.
REQ-011 KBD_DATA  input  CHAR_W  keyboard character.
REQ-012 KBD_READY  output  1  FIFO can accept; equals registered not-full.
REQ-013 DSP_VALID  output  1  display character pending.
REQ-014 DSP_DATA  output  CHAR_W  display character; stable while DSP_VALID high.
REQ-015 DSP_READY  input  1  display consumes character.
REQ-016 INT_REQ  output  1  combinational OR of enabled device-ready conditions.

Function
REQ-017 Keyboard push SHALL occur when KBD_VALID and KBD_READY are both high; KBD_DATA written at tail, count +1.
REQ-018 KBD_VALID high while FIFO full SHALL drop the character and set sticky overrun flag OVR; FIFO unchanged.
REQ-019 KBSR read SHALL return bit15 = FIFO non-empty, bit14 = KIE, bit13 = OVR, other bits 0.
REQ-020 KBSR write SHALL load KIE from MDR_OUT[14]; MDR_OUT[13] = 1 SHALL clear OVR (write-1-to-clear); other bits ignored.
REQ-021 KBDR read SHALL return FIFO head zero-extended to WIDTH and pop it in the same cycle; read when empty returns 0 and does not pop.
REQ-022 KBDR write SHALL be ignored.
REQ-023 Simultaneous push and pop SHALL both take effect, count unchanged; a push into an empty FIFO is not visible to a pop in the same cycle (no bypass).
REQ-024 KBD_READY SHALL be computed from registered count, so a push while full is refused even if a pop occurs the same cycle.
REQ-025 FIFO head/tail pointers SHALL wrap modulo KBD_DEPTH; count range 0..KBD_DEPTH.
REQ-026 Display FSM SHALL have states IDLE (DSP_VALID = 0) and BUSY (DSP_VALID = 1).
REQ-027 IDLE -> BUSY on DDR write: DSP_DATA <= MDR_OUT[CHAR_W-1:0], DSP_VALID high from next cycle.
REQ-028 BUSY -> IDLE on cycle where DSP_READY is high; DSP_VALID low from next cycle; DSP_DATA retained.
REQ-029 DDR write while BUSY SHALL be ignored (DSP_DATA unchanged).
REQ-030 DSR read SHALL return bit15 = (state == IDLE), bit14 = DIE, others 0; DSR write loads DIE from MDR_OUT[14].
REQ-031 DDR read SHALL return DSP_DATA zero-extended.
REQ-032 INT_REQ SHALL equal (KIE and FIFO non-empty) or (DIE and state == IDLE).
REQ-033 Accesses with MEM_EN low or IO_SEL low SHALL not change any state.

Reset
REQ-034 While i_Rst_n is low at a rising edge: FIFO emptied (count, pointers 0), OVR = 0, KIE = 0, DIE = 0, state = IDLE, DSP_VALID = 0, DSP_DATA = 0; reset overrides any push, pop or write in that cycle, including mid-transfer BUSY.
REQ-035 After reset: KBD_READY = 1, INT_REQ = 0, KBSR reads 16'h0000, DSR reads 16'h8000.

Verification
REQ-036 Push 'A' (8'h41) -> KBSR reads 16'h8000; KBDR read returns 16'h0041; KBSR then 16'h0000.
REQ-037 Push 5 chars with KBD_DEPTH = 4 -> KBD_READY low after 4th, KBSR = 16'hA000; 4 KBDR reads return chars 1..4 in order; KBSR write 16'h2000 clears OVR.
REQ-038 FIFO holding 2 chars, push and KBDR read same cycle -> count stays 2, read returns oldest; pointer wrap exercised over 10 push/pop pairs with correct order.
REQ-039 DDR write 16'h0042 -> DSP_VALID high next cycle, DSP_DATA 8'h42, DSR 16'h0000; second DDR write 16'h0043 while busy ignored; DSP_READY pulse -> DSP_VALID low next cycle, DSR 16'h8000.
REQ-040 KSR write 16'h4000, push char -> INT_REQ high; DSR write 16'h4000 with display IDLE -> INT_REQ high with empty FIFO.
REQ-041 Assert i_Rst_n low while display BUSY and FIFO holding 3 chars -> next cycle DSP_VALID 0, KBD_READY 1, KBSR 16'h0000, DSR 16'h8000.

Source files
------------

// File: rtl/mmio_kbd_dsp.sv
// Memory-mapped keyboard/display controller: four-register window with a
// keyboard receive FIFO, a single-character display holding register and a shared interrupt.
module mmio_kbd_dsp #(
    parameter int unsigned     WIDTH     = 16,
    parameter int unsigned     CHAR_W    = 8,
    parameter int unsigned     KBD_DEPTH = 4,
    parameter logic [WIDTH-1:0] BASE_ADDR = 16'hFE00
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic [WIDTH-1:0]  MAR_OUT,
    input  logic              MEM_EN,
    input  logic              R_W,
    input  logic [WIDTH-1:0]  MDR_OUT,
    output logic              IO_SEL,
    output logic [WIDTH-1:0]  IO_RDATA,
    input  logic              KBD_VALID,
    input  logic [CHAR_W-1:0] KBD_DATA,
    output logic              KBD_READY,
    output logic              DSP_VALID,
    output logic [CHAR_W-1:0] DSP_DATA,
    input  logic              DSP_READY,
    output logic              INT_REQ
);

    localparam int unsigned PTR_W = $clog2(KBD_DEPTH);
    localparam int unsigned CNT_W = $clog2(KBD_DEPTH + 1);

    localparam logic [WIDTH-1:0] KBSR_ADDR = BASE_ADDR;
    localparam logic [WIDTH-1:0] KBDR_ADDR = BASE_ADDR + WIDTH'(2);
    localparam logic [WIDTH-1:0] DSR_ADDR  = BASE_ADDR + WIDTH'(4);
    localparam logic [WIDTH-1:0] DDR_ADDR  = BASE_ADDR + WIDTH'(6);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } dsp_state_e;

    logic [CHAR_W-1:0] fifo_mem [KBD_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovr_q, ovr_d, kie_q, kie_d, die_q, die_d;
    dsp_state_e        state_q, state_d;
    logic [CHAR_W-1:0] dsp_data_q, dsp_data_d;

    logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
    logic rd_acc, wr_acc;
    logic fifo_full, fifo_nempty, push, pop, overrun;
    logic unused_mdr;

    // Address decode and access qualification
    assign sel_kbsr = (MAR_OUT == KBSR_ADDR);
    assign sel_kbdr = (MAR_OUT == KBDR_ADDR);
    assign sel_dsr  = (MAR_OUT == DSR_ADDR);
    assign sel_ddr  = (MAR_OUT == DDR_ADDR);
    assign IO_SEL   = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;
    assign rd_acc   = MEM_EN & ~R_W;
    assign wr_acc   = MEM_EN & R_W;
    assign unused_mdr = ^MDR_OUT;

    // Fullness comes from the registered count only, so a same-cycle pop never frees a slot
    assign fifo_full   = (count_q == CNT_W'(KBD_DEPTH));
    assign fifo_nempty = (count_q != '0);
    assign KBD_READY   = ~fifo_full;
    assign push        = KBD_VALID & ~fifo_full;
    assign overrun     = KBD_VALID & fifo_full;
    assign pop         = rd_acc & sel_kbdr & fifo_nempty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Status/control bits; a new overrun wins over a same-cycle clear
    always_comb begin
        ovr_d = ovr_q;
        kie_d = kie_q;
        die_d = die_q;
        if (wr_acc && sel_kbsr) begin
            kie_d = MDR_OUT[WIDTH-2];
            if (MDR_OUT[WIDTH-3]) ovr_d = 1'b0;
        end
        if (overrun) ovr_d = 1'b1;
        if (wr_acc && sel_dsr) die_d = MDR_OUT[WIDTH-2];
    end

    // Display FSM next state
    always_comb begin
        state_d    = state_q;
        dsp_data_d = dsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (wr_acc && sel_ddr) begin
                    state_d    = S_BUSY;
                    dsp_data_d = MDR_OUT[CHAR_W-1:0];
                end
            end
            S_BUSY: begin
                if (DSP_READY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            kie_q      <= 1'b0;
            die_q      <= 1'b0;
            state_q    <= S_IDLE;
            dsp_data_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ovr_q      <= ovr_d;
            kie_q      <= kie_d;
            die_q      <= die_d;
            state_q    <= state_d;
            dsp_data_q <= dsp_data_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid
    always_ff @(posedge i_Clk) begin
        if (i_Rst_n && push) fifo_mem[tail_q] <= KBD_DATA;
    end

    always_comb begin
        IO_RDATA = '0;
        if (sel_kbsr) begin
            IO_RDATA[WIDTH-1] = fifo_nempty;
            IO_RDATA[WIDTH-2] = kie_q;
            IO_RDATA[WIDTH-3] = ovr_q;
        end else if (sel_kbdr) begin
            if (fifo_nempty) IO_RDATA = WIDTH'(fifo_mem[head_q]);
        end else if (sel_dsr) begin
            IO_RDATA[WIDTH-1] = (state_q == S_IDLE);
            IO_RDATA[WIDTH-2] = die_q;
        end else if (sel_ddr) begin
            IO_RDATA = WIDTH'(dsp_data_q);
        end
    end

    assign DSP_VALID = (state_q == S_BUSY);
    assign DSP_DATA  = dsp_data_q;
    assign INT_REQ   = (kie_q & fifo_nempty) | (die_q & (state_q == S_IDLE));

endmodule

// File: tb/tb_mmio_kbd_dsp.sv
// Directed bench for mmio_kbd_dsp: stimulus queues expected read/display data,
// a negedge monitor pops and compares whenever the DUT presents a read or a display handshake.
module tb_mmio_kbd_dsp;

    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;
    localparam logic [15:0] DSR  = 16'hFE04;
    localparam logic [15:0] DDR  = 16'hFE06;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n = 1'b0;
    logic [15:0] MAR_OUT = '0;
    logic        MEM_EN = 1'b0;
    logic        R_W = 1'b0;
    logic [15:0] MDR_OUT = '0;
    logic        IO_SEL;
    logic [15:0] IO_RDATA;
    logic        KBD_VALID = 1'b0;
    logic [7:0]  KBD_DATA = '0;
    logic        KBD_READY;
    logic        DSP_VALID;
    logic [7:0]  DSP_DATA;
    logic        DSP_READY = 1'b0;
    logic        INT_REQ;

    mmio_kbd_dsp #(
        .WIDTH(16), .CHAR_W(8), .KBD_DEPTH(4), .BASE_ADDR(16'hFE00)
    ) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .MAR_OUT(MAR_OUT), .MEM_EN(MEM_EN),
        .R_W(R_W), .MDR_OUT(MDR_OUT), .IO_SEL(IO_SEL), .IO_RDATA(IO_RDATA),
        .KBD_VALID(KBD_VALID), .KBD_DATA(KBD_DATA), .KBD_READY(KBD_READY),
        .DSP_VALID(DSP_VALID), .DSP_DATA(DSP_DATA), .DSP_READY(DSP_READY),
        .INT_REQ(INT_REQ)
    );

    always #5 i_Clk = ~i_Clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] rd_exp_q [$];
    string       rd_name_q [$];
    logic [7:0]  dsp_exp_q [$];
    logic [7:0]  model_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented read and every display handshake
    always @(negedge i_Clk) begin
        logic [15:0] e;
        logic [7:0]  d;
        string       n;
        if (i_Rst_n && MEM_EN && !R_W && IO_SEL) begin
            if (rd_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: addr %0h data %0h with nothing expected", MAR_OUT, IO_RDATA);
            end else begin
                e = rd_exp_q.pop_front();
                n = rd_name_q.pop_front();
                chk(n, 32'(IO_RDATA), 32'(e));
            end
        end
        if (i_Rst_n && DSP_VALID && DSP_READY) begin
            if (dsp_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_display: data %0h with nothing expected", DSP_DATA);
            end else begin
                d = dsp_exp_q.pop_front();
                chk("display_char", 32'(DSP_DATA), 32'(d));
            end
        end
    end

    task automatic step();
        @(posedge i_Clk);
        #1;
        MEM_EN    = 1'b0;
        R_W       = 1'b0;
        KBD_VALID = 1'b0;
        DSP_READY = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        MAR_OUT = addr;
        MEM_EN  = 1'b1;
        R_W     = 1'b0;
        step();
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        MAR_OUT = addr;
        MDR_OUT = data;
        MEM_EN  = 1'b1;
        R_W     = 1'b1;
        step();
    endtask

    task automatic kpush(input logic [7:0] ch);
        KBD_VALID = 1'b1;
        KBD_DATA  = ch;
        step();
    endtask

    task automatic push_rd(input logic [7:0] ch, input logic [15:0] exp, input string name);
        KBD_VALID = 1'b1;
        KBD_DATA  = ch;
        rd(KBDR, exp, name);
    endtask

    initial begin
        logic [7:0] ch;
        logic [7:0] old;

        step();
        step();
        i_Rst_n = 1'b1;
        chk("reset_kbd_ready", 32'(KBD_READY), 32'd1);
        chk("reset_int_req", 32'(INT_REQ), 32'd0);
        chk("reset_dsp_valid", 32'(DSP_VALID), 32'd0);
        rd(KBSR, 16'h0000, "reset_kbsr");
        rd(DSR, 16'h8000, "reset_dsr");

        // Unmapped address
        MAR_OUT = 16'hFE08; MEM_EN = 1'b1; R_W = 1'b0;
        #1;
        chk("unmapped_io_sel", 32'(IO_SEL), 32'd0);
        chk("unmapped_rdata", 32'(IO_RDATA), 32'd0);
        step();

        // Single character round trip, including a non-strobed KBDR address
        kpush(8'h41);
        rd(KBSR, 16'h8000, "kbsr_one");
        MAR_OUT = KBDR; MEM_EN = 1'b0; R_W = 1'b0;
        step();
        rd(KBDR, 16'h0041, "kbdr_A");
        rd(KBSR, 16'h0000, "kbsr_empty");
        rd(KBDR, 16'h0000, "kbdr_empty");
        wr(KBDR, 16'h00FF);
        rd(KBSR, 16'h0000, "kbdr_write_ignored");

        // Overrun
        for (int i = 0; i < 5; i++) begin
            kpush(8'h31 + 8'(i));
            if (i == 3) chk("full_kbd_ready", 32'(KBD_READY), 32'd0);
        end
        rd(KBSR, 16'hA000, "kbsr_overrun");
        for (int i = 0; i < 4; i++) rd(KBDR, 16'h0031 + 16'(i), "kbdr_order");
        rd(KBSR, 16'h2000, "kbsr_ovr_sticky");
        wr(KBSR, 16'h2000);
        rd(KBSR, 16'h0000, "kbsr_ovr_cleared");

        // Simultaneous push/pop with pointer wrap
        model_q.delete();
        kpush(8'h50); model_q.push_back(8'h50);
        kpush(8'h51); model_q.push_back(8'h51);
        for (int i = 0; i < 10; i++) begin
            ch  = 8'h60 + 8'(i);
            old = model_q.pop_front();
            model_q.push_back(ch);
            push_rd(ch, 16'(old), "pair_rd");
        end
        rd(KBSR, 16'h8000, "pair_nonempty");
        while (model_q.size() > 0) begin
            old = model_q.pop_front();
            rd(KBDR, 16'(old), "pair_drain");
        end
        rd(KBSR, 16'h0000, "pair_count_two");

        // Full FIFO: push refused even with same-cycle pop
        for (int i = 0; i < 4; i++) kpush(8'h70 + 8'(i));
        chk("full2_kbd_ready", 32'(KBD_READY), 32'd0);
        push_rd(8'h7F, 16'h0070, "full_pop");
        for (int i = 1; i < 4; i++) rd(KBDR, 16'h0070 + 16'(i), "full_drain");
        rd(KBSR, 16'h2000, "full_push_refused");
        wr(KBSR, 16'h2000);

        // No bypass from push to pop when empty
        push_rd(8'h7A, 16'h0000, "nobypass_rd");
        rd(KBDR, 16'h007A, "nobypass_later");
        rd(KBSR, 16'h0000, "nobypass_empty");

        // Display path
        wr(DDR, 16'h0042);
        chk("dsp_valid_set", 32'(DSP_VALID), 32'd1);
        chk("dsp_data", 32'(DSP_DATA), 32'h42);
        rd(DSR, 16'h0000, "dsr_busy");
        wr(DDR, 16'h0043);
        chk("dsp_data_busy_write", 32'(DSP_DATA), 32'h42);
        rd(DDR, 16'h0042, "ddr_read");
        dsp_exp_q.push_back(8'h42);
        DSP_READY = 1'b1;
        step();
        chk("dsp_valid_clear", 32'(DSP_VALID), 32'd0);
        rd(DSR, 16'h8000, "dsr_idle");
        rd(DDR, 16'h0042, "ddr_retained");

        // Interrupts
        wr(KBSR, 16'h4000);
        chk("int_kie_empty", 32'(INT_REQ), 32'd0);
        kpush(8'h21);
        chk("int_kbd", 32'(INT_REQ), 32'd1);
        rd(KBSR, 16'hC000, "kbsr_kie");
        rd(KBDR, 16'h0021, "kbdr_int_char");
        chk("int_kbd_drained", 32'(INT_REQ), 32'd0);
        wr(DSR, 16'h4000);
        chk("int_dsp_idle", 32'(INT_REQ), 32'd1);
        rd(DSR, 16'hC000, "dsr_die");
        wr(DDR, 16'h0055);
        chk("int_dsp_busy", 32'(INT_REQ), 32'd0);
        rd(DSR, 16'h4000, "dsr_die_busy");

        // Reset mid-transfer with FIFO partly full
        for (int i = 0; i < 3; i++) kpush(8'h01 + 8'(i));
        rd(KBSR, 16'hC000, "kbsr_pre_reset");
        i_Rst_n = 1'b0;
        KBD_VALID = 1'b1; KBD_DATA = 8'h99;
        MAR_OUT = DSR; MDR_OUT = 16'h4000; MEM_EN = 1'b1; R_W = 1'b1;
        step();
        i_Rst_n = 1'b1;
        chk("rst_dsp_valid", 32'(DSP_VALID), 32'd0);
        chk("rst_kbd_ready", 32'(KBD_READY), 32'd1);
        chk("rst_int_req", 32'(INT_REQ), 32'd0);
        chk("rst_dsp_data", 32'(DSP_DATA), 32'd0);
        rd(KBSR, 16'h0000, "rst_kbsr");
        rd(DSR, 16'h8000, "rst_dsr");
        rd(DDR, 16'h0000, "rst_ddr");

        step();
        chk("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        chk("dsp_queue_drained", 32'(dsp_exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
